fuzzy_sweep_ctrl: RTL and testbench

FUZZY_SWEEP_CTRL -- requirements
Module: fuzzy_sweep_ctrl

---
 rtl/fuzzy_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_fuzzy_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_sweep_ctrl.sv
// Sweeps a two-input fuzzy controller over a STEP-spaced grid and streams
// {entrada_01, entrada_02, saida_defuzzy} words. SWEEP_CHECKSUM_EN adds a checksum accumulator.
module fuzzy_sweep_ctrl #(
  parameter int unsigned STEP   = 16,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned MAXV   = 255
) (
  input  logic        clk_0,
  input  logic        Srst,
  input  logic        start,
  output logic [7:0]  entrada_01,
  output logic [7:0]  entrada_02,
  output logic        en_regras,
  input  logic [7:0]  saida_defuzzy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [8:0] STEP9     = 9'(STEP);
  localparam logic [8:0] MAXV9     = 9'(MAXV);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  settle_cnt;
  logic [8:0]  e1_sum;
  logic [8:0]  e2_sum;
  logic        e1_fits;
  logic        e2_fits;

  // Nine-bit sums keep the axis from wrapping past 255 back into range.
  assign e1_sum  = {1'b0, entrada_01} + STEP9;
  assign e2_sum  = {1'b0, entrada_02} + STEP9;
  assign e1_fits = (e1_sum <= MAXV9);
  assign e2_fits = (e2_sum <= MAXV9);

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_APPLY;
      S_APPLY:   state_nx = S_SETTLE;
      S_SETTLE:  if (settle_cnt == '0) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_SEND;
      S_SEND:    if (res_ready) state_nx = S_NEXT;
      S_NEXT:    state_nx = (e2_fits || e1_fits) ? S_APPLY : S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_regras = 1'b0;
    res_valid = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_APPLY, S_SETTLE, S_CAPTURE: en_regras = 1'b1;
      S_SEND:                       res_valid = 1'b1;
      S_DONE:                       done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      settle_cnt <= '0;
      entrada_01 <= '0;
      entrada_02 <= '0;
      res_data   <= '0;
    end else begin
      case (state)
        S_APPLY:   settle_cnt <= SETTLE_LD;
        S_SETTLE:  if (settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
        S_CAPTURE: res_data <= {entrada_01, entrada_02, saida_defuzzy};
        S_NEXT: begin
          if (e2_fits) begin
            entrada_02 <= e2_sum[7:0];
          end else begin
            entrada_02 <= '0;
            if (e1_fits) entrada_01 <= e1_sum[7:0];
          end
        end
        S_DONE: begin
          entrada_01 <= '0;
          entrada_02 <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_CHECKSUM_EN
  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst)                          checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_CAPTURE)       checksum <= checksum + {8'd0, saida_defuzzy};
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fuzzy_sweep_ctrl.sv
// Directed bench for fuzzy_sweep_ctrl: three instances cover the small grid,
// the MAXV-bounded grid and the full default sweep.
module tb_fuzzy_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: STEP=128, SETTLE=2
  logic        start_a, rdy_a, en_a, valid_a, busy_a, done_a;
  logic [7:0]  saida_a, e1_a, e2_a;
  logic [23:0] data_a;
  logic [15:0] ck_a;
  // Instance B: STEP=50, SETTLE=3, MAXV=100
  logic        start_b, rdy_b, en_b, valid_b, busy_b, done_b;
  logic [7:0]  saida_b, e1_b, e2_b;
  logic [23:0] data_b;
  logic [15:0] ck_b;
  // Instance C: defaults
  logic        start_c, rdy_c, en_c, valid_c, busy_c, done_c;
  logic [7:0]  saida_c, e1_c, e2_c;
  logic [23:0] data_c;
  logic [15:0] ck_c;

  fuzzy_sweep_ctrl #(.STEP(128), .SETTLE(2), .MAXV(255)) dut_a (
    .clk_0(clk), .Srst(rst), .start(start_a), .entrada_01(e1_a), .entrada_02(e2_a),
    .en_regras(en_a), .saida_defuzzy(saida_a), .res_valid(valid_a), .res_ready(rdy_a),
    .res_data(data_a), .busy(busy_a), .done(done_a), .checksum(ck_a));

  fuzzy_sweep_ctrl #(.STEP(50), .SETTLE(3), .MAXV(100)) dut_b (
    .clk_0(clk), .Srst(rst), .start(start_b), .entrada_01(e1_b), .entrada_02(e2_b),
    .en_regras(en_b), .saida_defuzzy(saida_b), .res_valid(valid_b), .res_ready(rdy_b),
    .res_data(data_b), .busy(busy_b), .done(done_b), .checksum(ck_b));

  fuzzy_sweep_ctrl dut_c (
    .clk_0(clk), .Srst(rst), .start(start_c), .entrada_01(e1_c), .entrada_02(e2_c),
    .en_regras(en_c), .saida_defuzzy(saida_c), .res_valid(valid_c), .res_ready(rdy_c),
    .res_data(data_c), .busy(busy_c), .done(done_c), .checksum(ck_c));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_zero(input string pfx);
    check({pfx, "_e1"},    32'(e1_a), 32'h0);
    check({pfx, "_e2"},    32'(e2_a), 32'h0);
    check({pfx, "_en"},    32'(en_a), 32'h0);
    check({pfx, "_valid"}, 32'(valid_a), 32'h0);
    check({pfx, "_data"},  32'(data_a), 32'h0);
    check({pfx, "_busy"},  32'(busy_a), 32'h0);
    check({pfx, "_done"},  32'(done_a), 32'h0);
    check({pfx, "_ck"},    32'(ck_a), 32'h0);
  endtask

  logic [23:0] q[$];
  logic [23:0] exp_a1[4];
  logic [23:0] exp_a2[4];
  logic [23:0] d0;
  logic [7:0]  p1, p2;
  logic [23:0] exp_w;
  logic        stable, quiet, found, seen;
  int          done_cnt, done_at, w, maxv;

  initial begin
    exp_a1 = '{24'h000055, 24'h008055, 24'h800055, 24'h808055};
    exp_a2 = '{24'h00003C, 24'h0080FF, 24'h8000FF, 24'h8080FF};
    rst = 1'b1;
    start_a = 0; rdy_a = 0; saida_a = 0;
    start_b = 0; rdy_b = 0; saida_b = 0;
    start_c = 0; rdy_c = 0; saida_c = 0;
    tick(); tick();
    check_a_zero("reset");
    rst = 1'b0;
    tick();

    // Basic sweep: 4 words, done 24 cycles after first APPLY
    saida_a = 8'h55; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0;
    check("a_apply_busy", 32'(busy_a), 32'h1);
    check("a_apply_en",   32'(en_a), 32'h1);
    check("a_apply_pair", 32'({e1_a, e2_a}), 32'h0);
    q.delete(); done_cnt = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (valid_a && rdy_a) q.push_back(data_a);
      if (done_a) begin
        if (done_at < 0) done_at = c;
        done_cnt++;
      end
      tick();
    end
    check("a_word_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("a_word%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hDEADBEEF, 32'(exp_a1[i]));
    check("a_done_at",  32'(done_at), 32'd24);
    check("a_done_len", 32'(done_cnt), 32'd1);
    check("a_idle_busy", 32'(busy_a), 32'h0);
    check("a_idle_pair", 32'({e1_a, e2_a}), 32'h0);

    // Stall in SEND, late saida change, start while busy
    rdy_a = 0; saida_a = 8'h3C; start_a = 1;
    tick();
    start_a = 0;
    w = 0;
    while (!valid_a && w < 20) begin
      tick();
      w++;
    end
    check("a_stall_valid", 32'(valid_a), 32'h1);
    saida_a = 8'hFF;
    d0 = data_a; p1 = e1_a; p2 = e2_a;
    stable = 1'b1;
    start_a = 1;
    for (int c = 0; c < 20; c++) begin
      if (!valid_a || data_a !== d0 || e1_a !== p1 || e2_a !== p2) stable = 1'b0;
      tick();
      start_a = 0;
    end
    check("a_stall_stable", 32'(stable), 32'h1);
    check("a_stall_data",   32'(d0), 32'h00003C);
    rdy_a = 1;
    q.delete(); done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid_a && rdy_a) q.push_back(data_a);
      if (done_a) done_cnt++;
      tick();
    end
    check("a2_word_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("a2_word%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hDEADBEEF, 32'(exp_a2[i]));
    check("a2_done_len", 32'(done_cnt), 32'd1);
    check("a2_idle_busy", 32'(busy_a), 32'h0);
`ifdef SWEEP_CHECKSUM_EN
    check("a2_checksum", 32'(ck_a), 32'h0339);
`else
    check("a2_checksum", 32'(ck_a), 32'h0);
`endif

    // Reset during SETTLE of the third point
    saida_a = 8'h55; rdy_a = 1; start_a = 1;
    tick();
    start_a = 0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (en_a && e1_a == 8'h80 && e2_a == 8'h00) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("a3_third_point", 32'(found), 32'h1);
    tick();
    check("a3_settle_busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    #1;
    check_a_zero("a3_async");
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (valid_a || busy_a) quiet = 1'b0;
      tick();
    end
    check("a3_no_restart", 32'(quiet), 32'h1);

    // MAXV=100, STEP=50 grid
    saida_b = 8'h07; rdy_b = 1; start_b = 1;
    tick();
    start_b = 0;
    q.delete(); done_cnt = 0; maxv = 0;
    for (int c = 0; c < 120; c++) begin
      if (int'(e1_b) > maxv) maxv = int'(e1_b);
      if (int'(e2_b) > maxv) maxv = int'(e2_b);
      if (valid_b && rdy_b) q.push_back(data_b);
      if (done_b) done_cnt++;
      tick();
    end
    check("b_word_count", 32'(q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      exp_w = {8'((i / 3) * 50), 8'((i % 3) * 50), 8'h07};
      check($sformatf("b_word%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hDEADBEEF, 32'(exp_w));
    end
    check("b_max_driven", 32'(maxv), 32'd100);
    check("b_done_len", 32'(done_cnt), 32'd1);

    // Full default sweep
    saida_c = 8'h01; rdy_c = 1; start_c = 1;
    tick();
    start_c = 0;
    q.delete(); seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (valid_c && rdy_c) q.push_back(data_c);
      if (done_c) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("c_done_seen",  32'(seen), 32'h1);
    check("c_word_count", 32'(q.size()), 32'd256);
    check("c_first_word", (q.size() > 0) ? 32'(q[0]) : 32'hDEADBEEF, 32'h000001);
    check("c_last_word",  (q.size() > 0) ? 32'(q[q.size() - 1]) : 32'hDEADBEEF, 32'hF0F001);
    tick();
    check("c_idle_busy", 32'(busy_c), 32'h0);
`ifdef SWEEP_CHECKSUM_EN
    check("c_checksum", 32'(ck_c), 32'd256);
`else
    check("c_checksum", 32'(ck_c), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
